sensor_stream_rx: RTL
=====================

// Module: sensor_stream_rx
// PURPOSE
//  Receiving end of the sensor pixel interface (VSYNC/HSYNC + two RGB pixels per clock).
//  Frames the stream, checks line and frame geometry, and buffers pixel pairs in a small FIFO.
//  Emits pixel pairs on a valid/ready stream with SOF/EOL/EOF markers.
//  Sits between the sensor (or sensor model) and the downstream display/frame-buffer writer.
// PARAMETERS
//  IMG_PIX_W   8   bits per colour component
//  WIDTH       64  pixels per line (even); BEATS = WIDTH/2 beats per line
//  HEIGHT      64  lines per frame
//  FIFO_DEPTH  4   output FIFO entries (power of 2, >=2)
// PORTS
//  HCLK        in   1            clock, rising edge
//  HRESET      in   1            asynchronous reset, active-high
//  capture_en  in   1            sampled only at frame start; 0 = ignore the frame
//  VSYNC       in   1            rising edge = start of frame
//  HSYNC       in   1            high = DATA_* carry one valid pixel pair (beat)
//  DATA_R0/G0/B0 in IMG_PIX_W    even-column pixel
//  DATA_R1/G1/B1 in IMG_PIX_W    odd-column pixel
//  m_valid     out  1            output beat valid
//  m_ready     in   1            downstream accepts beat
//  m_data      out  6*IMG_PIX_W  {R0,G0,B0,R1,G1,B1}, R0 in the MSBs
//  m_sof       out  1            first beat of frame (qualified by m_valid)
//  m_eol       out  1            last beat of a line
//  m_eof       out  1            last beat of frame (also has m_eol=1)
//  busy        out  1            FSM not in IDLE
//  frame_done  out  1            one-cycle pulse, frame completed with no error
//  line_err    out  1            sticky: HSYNC run length != BEATS
//  frame_err   out  1            sticky: VSYNC rose before HEIGHT lines were received
//  ovf_err     out  1            sticky: beat arrived while FIFO was full
//  err_clr     in   1            synchronous clear of all sticky errors
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM=IDLE, counters 0, VSYNC/HSYNC edge registers 0.
//  Edge detection uses registered copies of VSYNC/HSYNC; beats are taken when HSYNC=1 in a cycle.
//  FSM states:
//   IDLE  -> WAIT on VSYNC rise with capture_en=1. With capture_en=0, stay in IDLE and ignore the frame.
//   WAIT  -> LINE on first HSYNC=1 beat. Clear col to 0.
//   LINE  -> counts beats in col. When HSYNC falls: if col!=BEATS, set line_err; row++.
//            If row reaches HEIGHT -> DONE, else -> WAIT.
//   DONE  -> IDLE after 1 cycle. Pulse frame_done if no error was set during this frame.
//  VSYNC rise in WAIT or LINE: set frame_err, reset row/col, go to WAIT (new frame, new SOF).
//  Tags (combinational on each written beat):
//   sof = row==0 && col==0
//   eol = col==BEATS-1
//   eof = eol && row==HEIGHT-1
//  Beats with col>=BEATS are dropped (line_err still set). Beats in IDLE or DONE are ignored.
//  Latency: beat sampled at edge N is written to the FIFO at edge N+1.
//   With the FIFO empty, m_valid is high after edge N+1.
//  FIFO: beat + tags, depth FIFO_DEPTH. Pop on m_valid&&m_ready. m_data/tags are stable while m_valid&&!m_ready.
//  Overflow: push while full and no pop in the same cycle -> beat dropped, ovf_err=1.
//   Push and pop in the same cycle while full are both legal.
//  err_clr in the same cycle as a new error: the error wins (flag stays 1).
//  Async reset mid-frame: FIFO flushed, m_valid drops immediately.
//   The next accepted frame starts only on a fresh VSYNC rise.
// TESTING
//  T1 64x64 frame, m_ready=1 -> 2048 beats, data matches source.
//     m_sof on beat 0, m_eol every 32nd beat, m_eof on beat 2047, frame_done=1 once, no error flags.
//  T2 same frame, m_ready toggling 1/0 every cycle, FIFO_DEPTH=4, source 1 beat/cycle -> ovf_err=1.
//     Accepted beats keep their order and m_data stays stable while stalled.
//  T3 line 5 has 31 beats -> line_err=1, no frame_done; the next frame with err_clr -> clean frame_done.
//  T4 VSYNC rises after 10 lines -> frame_err=1.
//     The next beat carries m_sof=1; full 64 lines after that -> m_eof on the last beat.
//  T5 capture_en=0 at VSYNC -> no m_valid for the whole frame, busy=0. capture_en=1 on the next frame -> normal capture.
//  T6 HRESET pulsed mid-line with 3 beats in the FIFO -> m_valid=0 and flags 0 right away.
//     No output until the next VSYNC rise.

Source files
------------

// File: rtl/sensor_stream_rx.sv
// Sensor pixel stream receiver: frames VSYNC/HSYNC beats (two RGB pixels
// per clock), checks line/frame geometry and buffers tagged beats in a FIFO.
// Ports: HCLK, HRESET (async, active-high); capture_en, VSYNC, HSYNC,
//   DATA_R0/G0/B0/R1/G1/B1 sensor side; m_valid, m_ready, m_data,
//   m_sof, m_eol, m_eof output stream; busy, frame_done, line_err,
//   frame_err, ovf_err status; err_clr clears the sticky errors.
module sensor_stream_rx #(
   parameter int IMG_PIX_W  = 8,
   parameter int WIDTH      = 64,
   parameter int HEIGHT     = 64,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                   HCLK,
   input  logic                   HRESET,
   input  logic                   capture_en,
   input  logic                   VSYNC,
   input  logic                   HSYNC,
   input  logic [IMG_PIX_W-1:0]   DATA_R0,
   input  logic [IMG_PIX_W-1:0]   DATA_G0,
   input  logic [IMG_PIX_W-1:0]   DATA_B0,
   input  logic [IMG_PIX_W-1:0]   DATA_R1,
   input  logic [IMG_PIX_W-1:0]   DATA_G1,
   input  logic [IMG_PIX_W-1:0]   DATA_B1,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [6*IMG_PIX_W-1:0] m_data,
   output logic                   m_sof,
   output logic                   m_eol,
   output logic                   m_eof,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   line_err,
   output logic                   frame_err,
   output logic                   ovf_err,
   input  logic                   err_clr
);

   localparam int BEATS = WIDTH / 2;
   // col saturates at BEATS+1 so over-long lines stay detectable
   localparam int CW = $clog2(BEATS + 2);
   localparam int RW = $clog2(HEIGHT + 1);
   localparam int DW = 6 * IMG_PIX_W;
   localparam int EW = DW + 3;
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_LINE,
      S_DONE
   } state_t;

   state_t        state_q;
   logic          vsync_q;
   logic          hsync_q;
   logic [CW-1:0] col_q;
   logic [RW-1:0] row_q;
   logic          stg_vld_q;
   logic [EW-1:0] stg_q;
   logic          line_err_q;
   logic          frame_err_q;
   logic          ovf_err_q;
   logic          err_seen_q;
   logic          frame_done_q;
   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]   wr_ptr_q;
   logic [AW:0]   rd_ptr_q;

   logic          vs_rise;
   logic          hs_fall;
   logic          in_frame;
   logic          take;
   logic          wr_beat;
   logic          t_sof;
   logic          t_eol;
   logic          t_eof;
   logic          line_set;
   logic          frame_set;
   logic          ovf_set;
   logic          fifo_full;
   logic          fifo_empty;
   logic          pop;
   logic          push;
   logic [EW-1:0] head;

   assign vs_rise  = VSYNC & ~vsync_q;
   assign hs_fall  = ~HSYNC & hsync_q;
   assign in_frame = (state_q == S_WAIT) || (state_q == S_LINE);
   // a VSYNC rise restarts the frame, so its beat is not taken
   assign take     = in_frame & HSYNC & ~vs_rise;
   assign wr_beat  = take & (col_q < CW'(BEATS));

   assign t_sof = (row_q == '0) && (col_q == '0);
   assign t_eol = col_q == CW'(BEATS - 1);
   assign t_eof = t_eol && (row_q == RW'(HEIGHT - 1));

   assign line_set  = (state_q == S_LINE) & ~vs_rise & hs_fall
                    & (col_q != CW'(BEATS));
   assign frame_set = in_frame & vs_rise;

   assign fifo_empty = wr_ptr_q == rd_ptr_q;
   assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0])
                     && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign pop        = ~fifo_empty & m_ready;
   assign push       = stg_vld_q & (~fifo_full | pop);
   assign ovf_set    = stg_vld_q & fifo_full & ~pop;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q      <= S_IDLE;
         vsync_q      <= 1'b0;
         hsync_q      <= 1'b0;
         col_q        <= '0;
         row_q        <= '0;
         stg_vld_q    <= 1'b0;
         stg_q        <= '0;
         line_err_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         ovf_err_q    <= 1'b0;
         err_seen_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         vsync_q      <= VSYNC;
         hsync_q      <= HSYNC;
         frame_done_q <= 1'b0;
         stg_vld_q    <= wr_beat;
         if (wr_beat) begin
            stg_q <= {DATA_R0, DATA_G0, DATA_B0,
                      DATA_R1, DATA_G1, DATA_B1,
                      t_sof, t_eol, t_eof};
         end
         // a new error beats a simultaneous clear
         line_err_q  <= line_set  | (line_err_q  & ~err_clr);
         frame_err_q <= frame_set | (frame_err_q & ~err_clr);
         ovf_err_q   <= ovf_set   | (ovf_err_q   & ~err_clr);
         if (line_set | frame_set | ovf_set) begin
            err_seen_q <= 1'b1;
         end
         if (take && (col_q <= CW'(BEATS))) begin
            col_q <= col_q + CW'(1);
         end
         unique case (state_q)
            S_IDLE: begin
               if (vs_rise && capture_en) begin
                  state_q    <= S_WAIT;
                  row_q      <= '0;
                  col_q      <= '0;
                  err_seen_q <= 1'b0;
               end
            end
            S_WAIT: begin
               if (vs_rise) begin
                  row_q <= '0;
                  col_q <= '0;
               end else if (HSYNC) begin
                  state_q <= S_LINE;
               end
            end
            S_LINE: begin
               if (vs_rise) begin
                  state_q <= S_WAIT;
                  row_q   <= '0;
                  col_q   <= '0;
               end else if (hs_fall) begin
                  col_q   <= '0;
                  row_q   <= row_q + RW'(1);
                  state_q <= (row_q == RW'(HEIGHT - 1)) ? S_DONE : S_WAIT;
               end
            end
            S_DONE: begin
               state_q      <= S_IDLE;
               frame_done_q <= ~err_seen_q;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge HCLK) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= stg_q;
   end

   assign head    = mem_q[rd_ptr_q[AW-1:0]];
   assign m_valid = ~fifo_empty;
   // gate the head so the stream reads zero while empty
   assign {m_data, m_sof, m_eol, m_eof} = fifo_empty ? '0 : head;

   assign busy       = state_q != S_IDLE;
   assign frame_done = frame_done_q;
   assign line_err   = line_err_q;
   assign frame_err  = frame_err_q;
   assign ovf_err    = ovf_err_q;

endmodule
